sim_camera_pattern_gen: RTL
===========================

Name: sim_camera_pattern_gen

Overview:
Parametrised simulation model of a parallel-bus image sensor; drives pixel clock, vsync, hsync and pixel data into the camera capture slave under test. Generalises the fixed single-pattern model: configurable frame geometry and blanking, data width, four selectable test patterns, run/stop control, frame counter and a flash strobe tied to frame boundaries. Simulation-only; sits in the testbench between the clock source and the capture core.

Parameters:
DATA_WIDTH, 8, pixel bus width in bits (1..16)
ROW_COUNT, 16, active rows per frame (>=1)
BYTE_COUNT, 32, pixels per row (>=1)
VBLANK_COUNT, 100, cycles of vertical blanking before each frame (>=1)
HBLANK_COUNT, 20, cycles of horizontal blanking between rows (>=1)

Ports:
i_cam_in_clk  in  1  camera input clock; all logic on rising edge
i_cam_rst  in  1  asynchronous reset, active-high
i_enable  in  1  run request; sampled at frame boundaries only
i_mode  in  2  pattern select; latched at VBLANK->ACTIVE transition
i_flash  in  1  flash request; rising edge arms strobe for next frame
o_pix_clk  out  1  equals i_cam_in_clk (combinational pass-through)
o_flash_strobe  out  1  high for the whole active period of an armed frame
o_vsync  out  1  high from first pixel of row 0 to last pixel of last row
o_hsync  out  1  high exactly while o_pix_data is valid
o_pix_data  out  DATA_WIDTH  pixel value; 0 whenever o_hsync low
o_frame_count  out  16  completed frames, wraps 0xFFFF->0
o_frame_done  out  1  one-cycle pulse on the last pixel cycle of each frame

Behaviour:
- Reset (async assert, sync release): all registered outputs 0, state IDLE, counters 0, flash arm cleared, latched mode 0.
- All outputs except o_pix_clk are registered; o_hsync, o_vsync, o_pix_data, o_flash_strobe change together.
- States: IDLE, VBLANK, ACTIVE, HBLANK.
- IDLE: vsync=hsync=0. If i_enable=1 -> VBLANK, blank counter cleared.
- VBLANK: vsync=hsync=0 for exactly VBLANK_COUNT cycles, then ACTIVE with row=0, col=0; mode latched; flash arm moved into strobe.
- ACTIVE: vsync=hsync=1, one pixel per cycle for exactly BYTE_COUNT cycles, col 0..BYTE_COUNT-1.
  - Last pixel, row<ROW_COUNT-1 -> HBLANK, row+1.
  - Last pixel, row=ROW_COUNT-1 -> o_frame_done=1 that cycle; o_frame_count+1 (visible next cycle); next state VBLANK if i_enable=1 else IDLE; strobe drops next cycle.
- HBLANK: vsync=1, hsync=0, data=0 for exactly HBLANK_COUNT cycles, then ACTIVE col=0.
- i_enable deassert mid-frame: frame completes normally, then IDLE. Reasserted during VBLANK: no effect (already running).
- Patterns (values truncated to DATA_WIDTH):
  - mode 0: linear counter, 0 at frame start, +1 per pixel, wraps at 2^DATA_WIDTH, continues across rows.
  - mode 1: row index.
  - mode 2: checkerboard, all-ones when (row^col)&1 else 0.
  - mode 3: constant o_frame_count[DATA_WIDTH-1:0] captured at frame start.
- i_mode changes mid-frame ignored until next VBLANK->ACTIVE.
- Flash: i_flash registered for edge detect; rising edge sets arm bit; arm transfers to o_flash_strobe at next ACTIVE entry and clears. Edge arriving during an active frame arms the following frame. Multiple edges before frame start = one strobe.
- Counter widths: $clog2 of the respective parameter plus 1; no overflow for legal parameters.

Decomposition:
- Shared package sim_camera_pkg: state enum (IDLE, VBLANK, ACTIVE, HBLANK), mode constants PAT_COUNT=0, PAT_ROW=1, PAT_CHECKER=2, PAT_FRAME=3.
- One sub-module natural: sim_camera_pattern (combinational pattern value from mode, row, col, linear count, frame number).

Test Plan:
- Defaults, mode 0, enable held: vsync low 100 cycles, then 16 rows of 32 hsync-high cycles with data 0..255 wrapping twice, 20-cycle hsync gaps; o_frame_done once per frame, count 1, 2.
- ROW_COUNT=4, BYTE_COUNT=4, mode 1: rows carry data 0,1,2,3 (four pixels each); mode 2: row 0 = 00,FF,00,FF, row 1 = FF,00,FF,00.
- Mode 3, third frame: every pixel = 0x02; change i_mode mid-frame -> no effect until next frame.
- Pulse i_flash during VBLANK -> o_flash_strobe high from first to last pixel of next frame only; pulse during active frame -> strobe on following frame.
- Drop i_enable at row 5 -> frame completes all 16 rows, enters IDLE, vsync/hsync/data stay 0; reassert -> VBLANK of 100 cycles then new frame.
- Assert i_cam_rst mid-row, asynchronously -> all outputs 0 same cycle, o_frame_count=0, restart from VBLANK after release with enable high.

Source files
------------

// File: rtl/sim_camera_pkg.sv
// Shared types and constants for the simulated parallel-bus camera source.
// Used by the pattern generator top, its pattern sub-module and the bench.
package sim_camera_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VBLANK = 2'd1,
      ACTIVE = 2'd2,
      HBLANK = 2'd3
   } cam_state_e;

   localparam logic [1:0] PAT_COUNT   = 2'd0;
   localparam logic [1:0] PAT_ROW     = 2'd1;
   localparam logic [1:0] PAT_CHECKER = 2'd2;
   localparam logic [1:0] PAT_FRAME   = 2'd3;

   // One spare bit so a counter can hold its terminal value without wrapping.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/sim_camera_pattern_gen_if.sv
// Video output bundle of the simulated camera: sync, pixel data and frame status.
interface sim_camera_pattern_gen_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  flash_strobe;
   logic                  vsync;
   logic                  hsync;
   logic [DATA_WIDTH-1:0] pix_data;
   logic [15:0]           frame_count;
   logic                  frame_done;

   modport master (
      output flash_strobe, vsync, hsync, pix_data, frame_count, frame_done
   );

   modport slave (
      input  flash_strobe, vsync, hsync, pix_data, frame_count, frame_done
   );
endinterface

// File: rtl/sim_camera_pattern.sv
// Combinational test-pattern value for one pixel position.
// Geometry and counters come from the caller; this block only selects the pattern.
module sim_camera_pattern
   import sim_camera_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ROW_W      = 5
) (
   input  logic [1:0]            mode_i,
   input  logic [ROW_W-1:0]      row_i,
   input  logic                  col_lsb_i,
   input  logic [DATA_WIDTH-1:0] lin_i,
   input  logic [DATA_WIDTH-1:0] frame_i,
   output logic [DATA_WIDTH-1:0] pix_o
);

   always_comb begin
      pix_o = '0;
      case (mode_i)
         PAT_COUNT:   pix_o = lin_i;
         PAT_ROW:     pix_o = DATA_WIDTH'(row_i);
         PAT_CHECKER: pix_o = (row_i[0] ^ col_lsb_i) ? '1 : '0;
         default:     pix_o = frame_i;
      endcase
   end

endmodule

// File: rtl/sim_camera_pattern_gen.sv
// Simulated parallel-bus image sensor: frame/line timing, selectable test patterns,
// run/stop control, frame counter and a frame-aligned flash strobe.
module sim_camera_pattern_gen
   import sim_camera_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ROW_COUNT    = 16,
   parameter int BYTE_COUNT   = 32,
   parameter int VBLANK_COUNT = 100,
   parameter int HBLANK_COUNT = 20
) (
   input  logic                     i_cam_in_clk,
   input  logic                     i_cam_rst,
   input  logic                     i_enable,
   input  logic [1:0]               i_mode,
   input  logic                     i_flash,
   output logic                     o_pix_clk,
   sim_camera_pattern_gen_if.master cam_o
);

   localparam int ROW_W = cnt_width(ROW_COUNT);
   localparam int COL_W = cnt_width(BYTE_COUNT);
   localparam int VB_W  = cnt_width(VBLANK_COUNT);
   localparam int HB_W  = cnt_width(HBLANK_COUNT);
   localparam int CNT_W = (VB_W > HB_W) ? VB_W : HB_W;

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_COUNT - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(BYTE_COUNT - 1);
   localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(VBLANK_COUNT - 1);
   localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HBLANK_COUNT - 1);

   cam_state_e            state_q, state_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [COL_W-1:0]      col_q, col_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] lin_q, lin_d;
   logic [1:0]            mode_q, mode_d;
   logic [DATA_WIDTH-1:0] fnum_q, fnum_d;
   logic                  arm_q, arm_d;
   logic                  flash_prev_q;
   logic                  strobe_q, strobe_d;
   logic [15:0]           frame_count_q, frame_count_d;
   logic                  done_q, done_d;
   logic                  vsync_q, hsync_q;
   logic [DATA_WIDTH-1:0] pix_q, pix_d;
   logic                  flash_rise;

   assign flash_rise = i_flash & ~flash_prev_q;

   // The _d values describe the cycle about to be shown, so the output
   // registers can be loaded from them and stay aligned with the state.
   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      col_d         = col_q;
      cnt_d         = cnt_q;
      lin_d         = lin_q;
      mode_d        = mode_q;
      fnum_d        = fnum_q;
      arm_d         = arm_q;
      strobe_d      = strobe_q;
      frame_count_d = frame_count_q;

      case (state_q)
         IDLE: begin
            if (i_enable) begin
               state_d = VBLANK;
               cnt_d   = '0;
            end
         end
         VBLANK: begin
            if (cnt_q == VB_LAST) begin
               state_d  = ACTIVE;
               row_d    = '0;
               col_d    = '0;
               lin_d    = '0;
               mode_d   = i_mode;
               fnum_d   = frame_count_q[DATA_WIDTH-1:0];
               strobe_d = arm_q;
               arm_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ACTIVE: begin
            lin_d = lin_q + DATA_WIDTH'(1);
            if (col_q == COL_LAST) begin
               col_d = '0;
               cnt_d = '0;
               if (row_q == ROW_LAST) begin
                  frame_count_d = frame_count_q + 16'd1;
                  strobe_d      = 1'b0;
                  state_d       = i_enable ? VBLANK : IDLE;
               end else begin
                  row_d   = row_q + ROW_W'(1);
                  state_d = HBLANK;
               end
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
         default: begin
            if (cnt_q == HB_LAST) begin
               state_d = ACTIVE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase

      // An edge coinciding with frame entry belongs to the following frame.
      if (flash_rise) begin
         arm_d = 1'b1;
      end

      done_d = (state_d == ACTIVE) && (col_d == COL_LAST) && (row_d == ROW_LAST);
   end

   sim_camera_pattern #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_W      (ROW_W)
   ) u_pattern (
      .mode_i    (mode_d),
      .row_i     (row_d),
      .col_lsb_i (col_d[0]),
      .lin_i     (lin_d),
      .frame_i   (fnum_d),
      .pix_o     (pix_d)
   );

   always_ff @(posedge i_cam_in_clk or posedge i_cam_rst) begin
      if (i_cam_rst) begin
         state_q       <= IDLE;
         row_q         <= '0;
         col_q         <= '0;
         cnt_q         <= '0;
         lin_q         <= '0;
         mode_q        <= PAT_COUNT;
         fnum_q        <= '0;
         arm_q         <= 1'b0;
         flash_prev_q  <= 1'b0;
         strobe_q      <= 1'b0;
         frame_count_q <= '0;
         done_q        <= 1'b0;
         vsync_q       <= 1'b0;
         hsync_q       <= 1'b0;
         pix_q         <= '0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         col_q         <= col_d;
         cnt_q         <= cnt_d;
         lin_q         <= lin_d;
         mode_q        <= mode_d;
         fnum_q        <= fnum_d;
         arm_q         <= arm_d;
         flash_prev_q  <= i_flash;
         strobe_q      <= strobe_d;
         frame_count_q <= frame_count_d;
         done_q        <= done_d;
         vsync_q       <= (state_d == ACTIVE) || (state_d == HBLANK);
         hsync_q       <= (state_d == ACTIVE);
         pix_q         <= (state_d == ACTIVE) ? pix_d : '0;
      end
   end

   assign o_pix_clk          = i_cam_in_clk;
   assign cam_o.flash_strobe = strobe_q;
   assign cam_o.vsync        = vsync_q;
   assign cam_o.hsync        = hsync_q;
   assign cam_o.pix_data     = pix_q;
   assign cam_o.frame_count  = frame_count_q;
   assign cam_o.frame_done   = done_q;

endmodule
